// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - UART 8N1 transmitter for 4-char ASCII words with optional CR/LF
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int APPEND_CRLF  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ascii_in,
  input  logic        data_valid,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX    = (APPEND_CRLF != 0) ? 3'd5 : 3'd3;

  logic [1:0]  state;
  logic        dv_q;
  logic [31:0] word;
  logic [2:0]  char_idx;
  logic [2:0]  bit_idx;
  logic [7:0]  byte_sr;
  logic [15:0] baud_cnt;
  logic [31:0] pend_word;
  logic        pend_valid;

  logic        new_word;
  logic        seq_end;
  logic        start_go;
  logic        from_pend;
  logic [31:0] start_word;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_at = w[31:24];
      3'd1:    byte_at = w[23:16];
      3'd2:    byte_at = w[15:8];
      3'd3:    byte_at = w[7:0];
      3'd4:    byte_at = 8'h0D;
      default: byte_at = 8'h0A;
    endcase
  endfunction

  assign new_word = data_valid & ~dv_q;
  // The NEXT decision is folded into the final STOP cycle so bytes and words run back-to-back.
  assign seq_end  = (state == ST_STOP) && (baud_cnt == 16'd0) && (char_idx == LAST_IDX);

  // Decide whether a word starts on this edge, and whether it comes from the pending buffer.
  always_comb begin
    start_go   = 1'b0;
    from_pend  = 1'b0;
    start_word = ascii_in;
    if ((state == ST_IDLE) || seq_end) begin
      if (pend_valid) begin
        start_go   = 1'b1;
        from_pend  = 1'b1;
        start_word = pend_word;
      end else if (new_word) begin
        start_go = 1'b1;
      end
    end
  end

  // Edge-detect register and one-deep pending buffer with overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q       <= 1'b0;
      pend_word  <= 32'd0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dv_q    <= data_valid;
      overrun <= 1'b0;
      if (new_word && !(start_go && !from_pend)) begin
        // A word consumed from pending this edge frees the slot, so no overrun then.
        pend_word  <= ascii_in;
        pend_valid <= 1'b1;
        overrun    <= pend_valid && !from_pend;
      end else if (from_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, per byte of the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      word     <= 32'd0;
      char_idx <= 3'd0;
      bit_idx  <= 3'd0;
      byte_sr  <= 8'd0;
      baud_cnt <= 16'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_go) begin
        word     <= start_word;
        char_idx <= 3'd0;
        byte_sr  <= start_word[31:24];
        tx       <= 1'b0;
        busy     <= 1'b1;
        baud_cnt <= BAUD_RELOAD;
        state    <= ST_START;
        if (seq_end) begin
          done <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            tx <= 1'b1;
          end
          ST_START: begin
            if (baud_cnt == 16'd0) begin
              state    <= ST_DATA;
              bit_idx  <= 3'd0;
              tx       <= byte_sr[0];
              baud_cnt <= BAUD_RELOAD;
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          ST_DATA: begin
            if (baud_cnt == 16'd0) begin
              baud_cnt <= BAUD_RELOAD;
              if (bit_idx == 3'd7) begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                byte_sr <= {1'b0, byte_sr[7:1]};
                tx      <= byte_sr[1];
              end
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          ST_STOP: begin
            if (baud_cnt == 16'd0) begin
              if (char_idx != LAST_IDX) begin
                char_idx <= char_idx + 3'd1;
                byte_sr  <= byte_at(word, char_idx + 3'd1);
                tx       <= 1'b0;
                baud_cnt <= BAUD_RELOAD;
                state    <= ST_START;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                tx    <= 1'b1;
                state <= ST_IDLE;
              end
            end else begin
              baud_cnt <= baud_cnt - 16'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
